// File: rtl/dff_bank_arbiter_if.sv
// Requester handshakes plus the registered bank write port of dff_bank_arbiter.
// master = requesters/bank side, slave = the arbiter.
interface dff_bank_arbiter_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
);
  logic              req_a;
  logic [ADDR_W-1:0] addr_a;
  logic [WIDTH-1:0]  data_a;
  logic              gnt_a;
  logic              req_b;
  logic [ADDR_W-1:0] addr_b;
  logic [WIDTH-1:0]  data_b;
  logic              gnt_b;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;

  modport master (
    output req_a, addr_a, data_a, req_b, addr_b, data_b,
    input  gnt_a, gnt_b, we, waddr, wdata
  );

  modport slave (
    input  req_a, addr_a, data_a, req_b, addr_b, data_b,
    output gnt_a, gnt_b, we, waddr, wdata
  );
endinterface

// File: rtl/dff_bank_arbiter.sv
// Init sweep + two-port write arbiter for a dff register bank.
// Define ARB_FIXED_PRIO_EN for fixed A-over-B priority; default is round-robin.
module dff_bank_arbiter #(
  parameter int               WIDTH    = 8,
  parameter int               ADDR_W   = 3,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             init_start,
  dff_bank_arbiter_if.slave bus,
  output logic             busy,
  output logic             init_done
);

  typedef enum logic {S_INIT, S_RUN} state_e;

  localparam logic [ADDR_W-1:0] CNT_LAST = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              pick_a;
  logic              xfer_a, xfer_b;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (clr) state_q <= S_INIT;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  if (cnt_q == CNT_LAST) state_d = S_RUN;
      S_RUN:   if (init_start)        state_d = S_INIT;
      default: state_d = S_INIT;
    endcase
  end

  // FSM: outputs; grants are blocked in reset, during the sweep and on the re-init cycle
  always_comb begin
    busy      = clr | (state_q == S_INIT);
    bus.gnt_a = 1'b0;
    bus.gnt_b = 1'b0;
    if (!clr && state_q == S_RUN && !init_start) begin
      bus.gnt_a = bus.req_a & (~bus.req_b |  pick_a);
      bus.gnt_b = bus.req_b & (~bus.req_a | ~pick_a);
    end
  end

  assign xfer_a = bus.req_a & bus.gnt_a;
  assign xfer_b = bus.req_b & bus.gnt_b;

`ifdef ARB_FIXED_PRIO_EN
  assign pick_a = 1'b1;
`else
  logic last_b_q, last_b_d;

  always_comb begin
    last_b_d = last_b_q;
    if (xfer_a)      last_b_d = 1'b0;
    else if (xfer_b) last_b_d = 1'b1;
  end

  // last starts as B so A takes the first tie
  always_ff @(posedge clk) begin
    if (clr) last_b_q <= 1'b1;
    else     last_b_q <= last_b_d;
  end

  assign pick_a = last_b_q;
`endif

  always_comb begin
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = done_q;
    if (state_q == S_INIT) begin
      we_d    = 1'b1;
      waddr_d = cnt_q;
      wdata_d = INIT_VAL;
      cnt_d   = cnt_q + ADDR_W'(1);
      if (cnt_q == CNT_LAST) done_d = 1'b1;
    end else begin
      if (init_start) done_d = 1'b0;
      if (xfer_a) begin
        we_d    = 1'b1;
        waddr_d = bus.addr_a;
        wdata_d = bus.data_a;
      end else if (xfer_b) begin
        we_d    = 1'b1;
        waddr_d = bus.addr_b;
        wdata_d = bus.data_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
    end
  end

  assign bus.we    = we_q;
  assign bus.waddr = waddr_q;
  assign bus.wdata = wdata_q;
  assign init_done = done_q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Scoreboard bench for dff_bank_arbiter: expected bank writes are queued when
// stimulus is driven and popped by a negedge monitor whenever we is high.
module tb_dff_bank_arbiter;
  localparam int          WIDTH  = 8;
  localparam int          ADDR_W = 3;
  localparam logic [7:0]  IV     = 8'h5A;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
  } wr_t;

  logic clk = 1'b0;
  logic clr, init_start, busy, init_done;
  int   errs = 0;
  int   nchk = 0;
  wr_t  sb[$];
  wr_t  mon_e;

  dff_bank_arbiter_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  dff_bank_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .INIT_VAL(IV)) dut (
    .clk        (clk),
    .clr        (clr),
    .init_start (init_start),
    .bus        (bus),
    .busy       (busy),
    .init_done  (init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input int a, input int d);
    wr_t e;
    e.addr = ADDR_W'(a);
    e.data = WIDTH'(d);
    sb.push_back(e);
  endtask

  task automatic push_sweep(input int n);
    for (int i = 0; i < n; i++) push_wr(i, IV);
  endtask

  // Runs a full sweep starting from an INIT cycle with cnt at 0.
  task automatic sweep_run();
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("sweep_busy", busy, 1);
      chk("sweep_gnt_a", bus.gnt_a, 0);
      chk("sweep_gnt_b", bus.gnt_b, 0);
      cyc();
      chk("sweep_we", bus.we, 1);
      chk("sweep_waddr", bus.waddr, i);
    end
    chk("sweep_end_busy", busy, 0);
    chk("sweep_end_done", init_done, 1);
  endtask

  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      if (sb.size() == 0) chk("sb_unexpected_we", 1, 0);
      else begin
        mon_e = sb.pop_front();
        chk("sb_waddr", bus.waddr, mon_e.addr);
        chk("sb_wdata", bus.wdata, mon_e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a_win;
    clr = 1'b1; init_start = 1'b0;
    bus.req_a = 1'b1; bus.addr_a = '0; bus.data_a = '0;
    bus.req_b = 1'b1; bus.addr_b = '0; bus.data_b = '0;

    // reset state, grants suppressed while clr is high
    cyc();
    chk("rst_we", bus.we, 0);
    chk("rst_waddr", bus.waddr, 0);
    chk("rst_wdata", bus.wdata, 0);
    chk("rst_done", init_done, 0);
    chk("rst_busy", busy, 1);
    chk("rst_gnt_a", bus.gnt_a, 0);
    chk("rst_gnt_b", bus.gnt_b, 0);
    cyc();
    clr = 1'b0; bus.req_a = 1'b0; bus.req_b = 1'b0;
    push_sweep(8);
    sweep_run();
    cyc();
    chk("post_init_we", bus.we, 0);

    // single requester A
    bus.req_a = 1'b1; bus.addr_a = 3'd3; bus.data_a = 8'hC3;
    #1;
    chk("single_a_gnt_a", bus.gnt_a, 1);
    chk("single_a_gnt_b", bus.gnt_b, 0);
    push_wr(3, 8'hC3);
    cyc();
    bus.req_a = 1'b0;
    chk("single_a_we", bus.we, 1);
    cyc();
    chk("single_a_we_off", bus.we, 0);

    // single requester B
    bus.req_b = 1'b1; bus.addr_b = 3'd6; bus.data_b = 8'h3C;
    #1;
    chk("single_b_gnt_b", bus.gnt_b, 1);
    chk("single_b_gnt_a", bus.gnt_a, 0);
    push_wr(6, 8'h3C);
    cyc();
    bus.req_b = 1'b0;
    chk("single_b_we", bus.we, 1);
    cyc();
    chk("single_b_we_off", bus.we, 0);

    // contention for 4 cycles
    bus.req_a = 1'b1; bus.req_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.addr_a = 3'(i);     bus.data_a = 8'hA0 + 8'(i);
      bus.addr_b = 3'(4 + i); bus.data_b = 8'hB0 + 8'(i);
      #1;
`ifdef ARB_FIXED_PRIO_EN
      a_win = 1'b1;
`else
      a_win = (i % 2 == 0);
`endif
      chk("cont_gnt_a", bus.gnt_a, a_win);
      chk("cont_gnt_b", bus.gnt_b, !a_win);
      chk("cont_both", bus.gnt_a & bus.gnt_b, 0);
      if (a_win) push_wr(i, 8'hA0 + i);
      else       push_wr(4 + i, 8'hB0 + i);
      cyc();
      chk("cont_we", bus.we, 1);
    end
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    cyc();
    chk("cont_we_off", bus.we, 0);

    // re-init while B is requesting
    bus.req_b = 1'b1; bus.addr_b = 3'd5; bus.data_b = 8'h77;
    init_start = 1'b1;
    #1;
    chk("reinit_gnt_b", bus.gnt_b, 0);
    chk("reinit_busy", busy, 0);
    push_sweep(8);
    cyc();
    init_start = 1'b0;
    chk("reinit_no_wr", bus.we, 0);
    chk("reinit_done_clr", init_done, 0);
    sweep_run();
    #1;
    chk("reinit_b_first", bus.gnt_b, 1);
    push_wr(5, 8'h77);
    cyc();
    bus.req_b = 1'b0;
    chk("reinit_b_we", bus.we, 1);
    cyc();
    chk("reinit_we_off", bus.we, 0);

    // clr in the sweep cycle that would write address 4
    init_start = 1'b1;
    #1;
    cyc();
    init_start = 1'b0;
    push_sweep(4);
    repeat (4) cyc();
    chk("mid_waddr3", bus.waddr, 3);
    clr = 1'b1;
    #1;
    chk("mid_busy", busy, 1);
    cyc();
    clr = 1'b0;
    chk("mid_we_drop", bus.we, 0);
    chk("mid_done", init_done, 0);
    push_sweep(8);
    sweep_run();
    cyc();
    chk("mid_end_we", bus.we, 0);
    chk("mid_end_done", init_done, 1);

    repeat (2) cyc();
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
- Write controller and two-port arbiter for a register bank built from dff primitives (2**ADDR_W words of WIDTH bits).
- After reset, or on command, it sweeps every word to INIT_VAL. It then shares the single bank write port between requesters A and B using req/gnt handshakes.
- It drives the bank's registered write strobe, address and data. It sits between the CPU control/writeback logic and the register bank.

Parameters:
- WIDTH, 8, data width of one bank word
- ADDR_W, 3, address width; the bank has DEPTH = 2**ADDR_W words, so every address is in range
- INIT_VAL, 0, value written to every word during the init sweep

Ports:
- clk  input  1  clock; all state updates on the posedge
- clr  input  1  reset, synchronous, active-high
- init_start  input  1  request a re-initialisation sweep; sampled only in RUN
- req_a  input  1  requester A write request; held until granted
- addr_a  input  ADDR_W  requester A write address
- data_a  input  WIDTH  requester A write data
- gnt_a  output  1  combinational grant to A; a transfer occurs in any cycle where req_a and gnt_a are both high
- req_b  input  1  requester B write request
- addr_b  input  ADDR_W  requester B write address
- data_b  input  WIDTH  requester B write data
- gnt_b  output  1  combinational grant to B
- we  output  1  registered bank write enable
- waddr  output  ADDR_W  registered bank write address
- wdata  output  WIDTH  registered bank write data
- busy  output  1  high while in INIT
- init_done  output  1  high from the first RUN cycle; cleared by clr or by re-entering INIT

Behaviour:
- Reset (clr high at a posedge) sets: state=INIT, cnt=0, we=0, waddr=0, wdata=0, last=B, init_done=0. busy=1 and gnt_a=gnt_b=0 while clr is high. clr overrides every other input in that cycle.
- States are INIT and RUN.
- INIT, each cycle:
  - gnt_a=gnt_b=0, busy=1.
  - Registers load we<=1, waddr<=cnt, wdata<=INIT_VAL, cnt<=cnt+1.
  - In the cycle where cnt==DEPTH-1, the state goes to RUN and cnt wraps to 0.
  - The sweep therefore takes exactly DEPTH cycles, writing addresses 0..DEPTH-1 in ascending order.
  - init_start is ignored during INIT.
- RUN, each cycle:
  - busy=0, init_done=1.
  - If init_start is high, the state goes to INIT next cycle and init_done goes to 0. Both grants are forced low in that cycle and no write is issued; pending requests wait until the sweep completes.
  - Otherwise grants are combinational from req_a, req_b and last:
    - only A requesting: gnt_a=1
    - only B requesting: gnt_b=1
    - both requesting: grant the one that is not last
  - On a transfer, registers load we<=1, waddr<=addr_x, wdata<=data_x, and last<=x. With no transfer, we<=0 and waddr/wdata hold their values.
- Latency: a transfer accepted in cycle t appears on we/waddr/wdata in cycle t+1.
- Throughput: one write per cycle; a requester holding req continuously gets every other cycle under contention.
- Grants never both high; gnt_x is never high without req_x.
- A request that drops before being granted is lost silently and needs no handling.
- clr mid-sweep or mid-transfer: the pending registered write of that cycle is discarded (we=0 next cycle) and the sweep restarts from address 0.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: A always wins when both request; last is not used for arbitration.
- Undefined (default): round-robin as described, with A winning the first tie after reset.

Test Plan:
- Reset and init sweep (ADDR_W=3, INIT_VAL=8'h5A): clr high for 2 cycles, then low -> busy=1 and we=1 for exactly 8 consecutive cycles with waddr=0..7 and wdata=8'h5A; then busy=0, init_done=1, we=0.
- Single requester: in RUN, req_a=1, addr_a=3, data_a=8'hC3 for one cycle -> gnt_a=1 in that cycle; we=1, waddr=3, wdata=8'hC3 next cycle, then we=0.
- Contention: req_a and req_b held high for 4 cycles with distinct data -> grants A,B,A,B; we high 4 consecutive cycles carrying matching addr/data; gnt_a and gnt_b never both high. With ARB_FIXED_PRIO_EN -> A granted all 4 cycles, B granted none.
- Re-init during traffic: init_start=1 while req_b=1 -> no grant that cycle; 8-cycle sweep follows with gnt_b=0 throughout; B granted on the first RUN cycle after.
- Reset mid-sweep: clr pulsed at sweep address 4 -> we=0 the next cycle, then the sweep restarts at waddr=0 and runs all 8 addresses.
